// File: rtl/pingpong_monitor.sv
// Receive-side checker for the pingpong counter: predicts value/direction from the
// previous sample and flags mismatches. Optional FAULT lock-up via PINGPONG_MON_STICKY_EN.
module pingpong_monitor #(
  parameter int              W         = 5,
  parameter logic [W-1:0]    MAX_VALUE = '1,
  parameter logic [W-1:0]    MIN_VALUE = '0,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     in_val,
  input  logic             in_dir,
  input  logic             in_max,
  input  logic             in_min,
  input  logic             in_hold,
  input  logic             in_flip,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             err_sticky,
  output logic [CNT_W-1:0] bounce_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOCK,
    TRACK
`ifdef PINGPONG_MON_STICKY_EN
    , FAULT
`endif
  } state_t;

  localparam logic [W-1:0] MAX_M1 = MAX_VALUE - 1'b1;
  localparam logic [W-1:0] MIN_P1 = MIN_VALUE + 1'b1;

  state_t           state, state_d;
  logic [W-1:0]     ref_val, ref_val_d;
  logic             ref_dir, ref_dir_d;
  logic             ref_hold, ref_hold_d;
  logic             ref_flip, ref_flip_d;
  logic             err_d;
  logic [1:0]       err_code_d;
  logic [CNT_W-1:0] bounce_cnt_d;
  logic             sticky, sticky_d;

  logic [W-1:0]     exp_val;
  logic             exp_dir;
  logic             val_bad, dir_bad, flag_bad;
  logic [1:0]       code;

  always_comb begin
    exp_val = ref_val;
    exp_dir = ref_dir;
    if (!ref_hold) begin
      exp_val = ref_dir ? ref_val - 1'b1 : ref_val + 1'b1;
      // bounce overrides beat a simultaneous flip
      if (ref_val == MAX_M1)      exp_dir = 1'b1;
      else if (ref_val == MIN_P1) exp_dir = 1'b0;
      else                        exp_dir = ref_dir ^ ref_flip;
    end
  end

  always_comb begin
    val_bad  = (in_val != exp_val);
    dir_bad  = (in_dir != exp_dir);
    flag_bad = (in_max != (in_val == MAX_VALUE)) || (in_min != (in_val == MIN_VALUE));
    if (val_bad)      code = 2'd1;
    else if (dir_bad) code = 2'd2;
    else              code = 2'd3;
  end

  always_comb begin
    state_d      = state;
    ref_val_d    = ref_val;
    ref_dir_d    = ref_dir;
    ref_hold_d   = ref_hold;
    ref_flip_d   = ref_flip;
    err_d        = 1'b0;
    err_code_d   = err_code;
    bounce_cnt_d = bounce_cnt;
    sticky_d     = sticky;
    case (state)
      IDLE: begin
        if (en) state_d = LOCK;
      end
      LOCK: begin
        ref_val_d  = in_val;
        ref_dir_d  = in_dir;
        ref_hold_d = in_hold;
        ref_flip_d = in_flip;
        state_d    = en ? TRACK : IDLE;
      end
      TRACK: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          ref_val_d  = in_val;
          ref_dir_d  = in_dir;
          ref_hold_d = in_hold;
          ref_flip_d = in_flip;
          if (in_dir != ref_dir && bounce_cnt != '1)
            bounce_cnt_d = bounce_cnt + 1'b1;
          if (val_bad || dir_bad || flag_bad) begin
            err_d      = 1'b1;
            err_code_d = code;
`ifdef PINGPONG_MON_STICKY_EN
            sticky_d   = 1'b1;
            state_d    = FAULT;
`endif
          end
        end
      end
`ifdef PINGPONG_MON_STICKY_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ref_val    <= '0;
      ref_dir    <= 1'b0;
      ref_hold   <= 1'b0;
      ref_flip   <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      bounce_cnt <= '0;
      sticky     <= 1'b0;
    end else begin
      state      <= state_d;
      ref_val    <= ref_val_d;
      ref_dir    <= ref_dir_d;
      ref_hold   <= ref_hold_d;
      ref_flip   <= ref_flip_d;
      err        <= err_d;
      err_code   <= err_code_d;
      bounce_cnt <= bounce_cnt_d;
      sticky     <= sticky_d;
    end
  end

  assign locked = (state == TRACK);

`ifdef PINGPONG_MON_STICKY_EN
  assign err_sticky = sticky;
`else
  assign err_sticky = 1'b0;
`endif

endmodule
